// File: rtl/lvds_serializer_if.sv
// Pixel-in / serial-out bundle for the 7:1 LVDS transmit stage.
// master: pixel source side (drives colour/sync, sees pix_tick and the lanes).
// slave : the serializer itself.
interface lvds_serializer_if;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       hsync;
  logic       vsync;
  logic       data_en;
  logic       pix_tick;
  logic [3:0] lane_data;
  logic       lane_clk;

  modport master (
    output R, G, B, hsync, vsync, data_en,
    input  pix_tick, lane_data, lane_clk
  );

  modport slave (
    input  R, G, B, hsync, vsync, data_en,
    output pix_tick, lane_data, lane_clk
  );
endinterface

// File: rtl/lvds_serializer.sv
// 7:1 FPD-Link/OpenLDI transmit stage: 4 data lanes + 1 clock lane, MSB first.
// Runs on the bit clock; pix_tick is the pixel-rate enable for upstream logic.
// Optional macro LVDS_JEIDA_EN selects JEIDA bit packing (default: VESA).

// One 7-bit serializer lane: parallel load, otherwise shift left zero-filled.
module lvds_lane_sr (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       en,
  input  logic       load,
  input  logic [6:0] word,
  output logic       ser
);
  logic [6:0] sr;

  // Load on pix_tick, shift when enabled, hold otherwise.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)  sr <= '0;
    else if (load) sr <= word;
    else if (en)   sr <= {sr[5:0], 1'b0};
  end

  assign ser = sr[6];
endmodule

module lvds_serializer #(
  parameter logic [6:0] CLK_PATTERN = 7'b1100011,
  parameter int         BLANK_RGB   = 1
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              en,
  lvds_serializer_if.slave  px
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 7;

  logic [2:0]                      phase;
  logic                            load;
  logic [7:0]                      r, g, b;
  logic [NUM_LANES-1:0][VEC_W-1:0] word;
  logic [NUM_LANES-1:0]            lane_ser;
  logic                            clk_ser;

  // Bit-position counter within the pixel word, 0..6.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)  phase <= 3'd0;
    else if (en)   phase <= (phase == 3'd6) ? 3'd0 : phase + 3'd1;
  end

  // Tick doubles as the load strobe; dropping en here suppresses the load.
  assign load        = en && (phase == 3'd6);
  assign px.pix_tick = load;

  // Blank colour slots during inactive video; sync/DE bits always pass through.
  always_comb begin
    r = px.R;
    g = px.G;
    b = px.B;
    if ((BLANK_RGB != 0) && !px.data_en) begin
      r = '0;
      g = '0;
      b = '0;
    end
  end

  // Map the pixel onto the four 7-bit lane words, bit 6 transmitted first.
  always_comb begin
    word = '0;
`ifdef LVDS_JEIDA_EN
    word[0] = {g[2], r[7:2]};
    word[1] = {b[3:2], g[7:3]};
    word[2] = {px.data_en, px.vsync, px.hsync, b[7:4]};
    word[3] = {1'b0, b[1:0], g[1:0], r[1:0]};
`else
    word[0] = {g[0], r[5:0]};
    word[1] = {b[1:0], g[5:1]};
    word[2] = {px.data_en, px.vsync, px.hsync, b[5:2]};
    word[3] = {1'b0, b[7:6], g[7:6], r[7:6]};
`endif
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    lvds_lane_sr u_lane (
      .clock   (clock),
      .reset_L (reset_L),
      .en      (en),
      .load    (load),
      .word    (word[n]),
      .ser     (lane_ser[n])
    );
  end

  lvds_lane_sr u_clk_lane (
    .clock   (clock),
    .reset_L (reset_L),
    .en      (en),
    .load    (load),
    .word    (CLK_PATTERN),
    .ser     (clk_ser)
  );

  assign px.lane_data = lane_ser;
  assign px.lane_clk  = clk_ser;
endmodule

// File: tb/tb_lvds_serializer.sv
// Directed bench for lvds_serializer; expectations follow LVDS_JEIDA_EN when defined.
module tb_lvds_serializer;
  logic clock = 1'b0;
  logic reset_L;
  logic en;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] CLKW = 7'b1100011;
  // Pattern R=A5 G=3C B=96 DE=1 HS=1 VS=0; lane 3 listed first.
`ifdef LVDS_JEIDA_EN
  localparam logic [3:0][6:0] EXP_A  = {7'h21, 7'h59, 7'h27, 7'h69};
  localparam logic [3:0][6:0] EXP_R3 = {7'h03, 7'h40, 7'h00, 7'h00};
`else
  localparam logic [3:0][6:0] EXP_A  = {7'h22, 7'h55, 7'h5E, 7'h25};
  localparam logic [3:0][6:0] EXP_R3 = {7'h00, 7'h40, 7'h00, 7'h03};
`endif
  // R=FF G=B=0 DE=1 packs identically in both builds.
  localparam logic [3:0][6:0] EXP_RED   = {7'h03, 7'h40, 7'h00, 7'h3F};
  localparam logic [3:0][6:0] EXP_BLANK = {7'h00, 7'h30, 7'h00, 7'h00};

  lvds_serializer_if px ();

  lvds_serializer dut (
    .clock   (clock),
    .reset_L (reset_L),
    .en      (en),
    .px      (px)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic set_pix(input logic [7:0] r, g, b, input logic de, hs, vs);
    px.R = r; px.G = g; px.B = b;
    px.data_en = de; px.hsync = hs; px.vsync = vs;
  endtask

  // Advance to the next negedge where pix_tick is high (bounded).
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (px.pix_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Sample the 7 bits that follow a load edge, MSB first.
  task automatic capture(output logic [3:0][6:0] lw, output logic [6:0] cw, output logic [6:0] tk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      for (int n = 0; n < 4; n++) lw[n][6-k] = px.lane_data[n];
      cw[6-k] = px.lane_clk;
      tk[6-k] = px.pix_tick;
    end
  endtask

  task automatic test_reset();
    logic [6:0] tk;
    logic       lanes_nz;
    reset_L = 1'b0;
    en = 1'b1;
    set_pix(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (px.lane_data !== 4'b0) begin errors++; $display("FAIL reset_lane_data got %b want 0000", px.lane_data); end
    checks++;
    if (px.lane_clk !== 1'b0) begin errors++; $display("FAIL reset_lane_clk got %b want 0", px.lane_clk); end
    checks++;
    if (px.pix_tick !== 1'b0) begin errors++; $display("FAIL reset_pix_tick got %b want 0", px.pix_tick); end
    reset_L = 1'b1;
    lanes_nz = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) @(negedge clock);
      tk[6-i] = px.pix_tick;
      if (px.lane_data !== 4'b0 || px.lane_clk !== 1'b0) lanes_nz = 1'b1;
    end
    checks++;
    if (tk !== 7'b0000001) begin errors++; $display("FAIL reset_first_tick got %b want 0000001", tk); end
    checks++;
    if (lanes_nz) begin errors++; $display("FAIL reset_idle_lanes got nonzero want 0"); end
  endtask

  task automatic test_clock_lane();
    bit ok;
    logic [3:0][6:0] lw;
    logic [6:0] cw, tk;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clk_tick_timeout got none want pix_tick"); end
    for (int w = 0; w < 10; w++) begin
      capture(lw, cw, tk);
      checks++;
      if (cw !== CLKW) begin errors++; $display("FAIL clk_word%0d got %b want %b", w, cw, CLKW); end
      checks++;
      if (tk !== 7'b0000001) begin errors++; $display("FAIL clk_tick_period%0d got %b want 0000001", w, tk); end
    end
  endtask

  task automatic test_pack(input string nm, input logic [7:0] r, g, b,
                           input logic de, hs, vs, input logic [3:0][6:0] exp);
    bit ok;
    logic [3:0][6:0] lw;
    logic [6:0] cw, tk;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_tick_timeout got none want pix_tick", nm); end
    set_pix(r, g, b, de, hs, vs);
    capture(lw, cw, tk);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (lw[n] !== exp[n]) begin errors++; $display("FAIL %s_L%0d got %b want %b", nm, n, lw[n], exp[n]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0][6:0] lw0, lw1;
    logic [6:0] cw0, cw1, tk0, tk1;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_tick_timeout got none want pix_tick"); end
    set_pix(8'hA5, 8'h3C, 8'h96, 1'b1, 1'b1, 1'b0);
    capture(lw0, cw0, tk0);
    set_pix(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    capture(lw1, cw1, tk1);
    checks++;
    if (lw0 !== EXP_A) begin errors++; $display("FAIL b2b_word0 got %h want %h", lw0, EXP_A); end
    checks++;
    if (lw1 !== EXP_RED) begin errors++; $display("FAIL b2b_word1 got %h want %h", lw1, EXP_RED); end
    checks++;
    if ({cw0, cw1} !== {CLKW, CLKW}) begin errors++; $display("FAIL b2b_clk got %b want %b", {cw0, cw1}, {CLKW, CLKW}); end
  endtask

  task automatic test_stall();
    bit ok, frozen_bad;
    logic [3:0][6:0] lw;
    logic [6:0] cw;
    logic [3:0] ld3;
    logic       lc3;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_tick_timeout got none want pix_tick"); end
    set_pix(8'hA5, 8'h3C, 8'h96, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      for (int n = 0; n < 4; n++) lw[n][6-k] = px.lane_data[n];
      cw[6-k] = px.lane_clk;
    end
    ld3 = px.lane_data;
    lc3 = px.lane_clk;
    en = 1'b0;
    frozen_bad = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      if (px.lane_data !== ld3 || px.lane_clk !== lc3 || px.pix_tick !== 1'b0) frozen_bad = 1'b1;
    end
    en = 1'b1;
    checks++;
    if (frozen_bad) begin errors++; $display("FAIL stall_frozen got change want hold %b/%b", ld3, lc3); end
    for (int k = 4; k < 7; k++) begin
      @(negedge clock);
      for (int n = 0; n < 4; n++) lw[n][6-k] = px.lane_data[n];
      cw[6-k] = px.lane_clk;
    end
    checks++;
    if (lw !== EXP_A) begin errors++; $display("FAIL stall_word got %h want %h", lw, EXP_A); end
    checks++;
    if (cw !== CLKW) begin errors++; $display("FAIL stall_clk got %b want %b", cw, CLKW); end
  endtask

  task automatic test_en_on_load();
    bit ok, frozen_bad;
    logic [3:0][6:0] lw;
    logic [6:0] cw, tk;
    logic [3:0] ld;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL enload_tick_timeout got none want pix_tick"); end
    set_pix(8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1);
    en = 1'b0;
    #1;
    checks++;
    if (px.pix_tick !== 1'b0) begin errors++; $display("FAIL enload_tick_gated got %b want 0", px.pix_tick); end
    ld = px.lane_data;
    frozen_bad = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (px.lane_data !== ld || px.pix_tick !== 1'b0) frozen_bad = 1'b1;
    end
    checks++;
    if (frozen_bad) begin errors++; $display("FAIL enload_hold got change want hold %b", ld); end
    en = 1'b1;
    set_pix(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (px.pix_tick !== 1'b1) begin errors++; $display("FAIL enload_tick_resume got %b want 1", px.pix_tick); end
    capture(lw, cw, tk);
    checks++;
    if (lw !== EXP_RED) begin errors++; $display("FAIL enload_word got %h want %h", lw, EXP_RED); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [6:0] tk;
    logic       lanes_nz;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_tick_timeout got none want pix_tick"); end
    set_pix(8'hA5, 8'h3C, 8'h96, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    checks++;
    if (px.lane_data === 4'b0) begin errors++; $display("FAIL rstmid_pre got %b want nonzero", px.lane_data); end
    reset_L = 1'b0;
    #1;
    checks++;
    if (px.lane_data !== 4'b0 || px.lane_clk !== 1'b0 || px.pix_tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got %b/%b/%b want 0000/0/0", px.lane_data, px.lane_clk, px.pix_tick);
    end
    @(negedge clock);
    reset_L = 1'b1;
    lanes_nz = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) @(negedge clock);
      tk[6-i] = px.pix_tick;
      if (px.lane_data !== 4'b0 || px.lane_clk !== 1'b0) lanes_nz = 1'b1;
    end
    checks++;
    if (tk !== 7'b0000001) begin errors++; $display("FAIL rstmid_restart got %b want 0000001", tk); end
    checks++;
    if (lanes_nz) begin errors++; $display("FAIL rstmid_idle got nonzero want 0"); end
  endtask

  initial begin
    test_reset();
    test_clock_lane();
    test_pack("vesa_red", 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, EXP_RED);
    test_pack("blank",    8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, EXP_BLANK);
    test_pack("mixed",    8'hA5, 8'h3C, 8'h96, 1'b1, 1'b1, 1'b0, EXP_A);
    test_pack("r03",      8'h03, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, EXP_R3);
    test_back_to_back();
    test_stall();
    test_en_on_load();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
